// File: rtl/dm_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dm_arbiter_pkg
// Shared definitions for the data-memory arbiter slice: default bus widths,
// starvation defaults and the read/write opcode encoding of the We signal.
// -----------------------------------------------------------------------------
package dm_arbiter_pkg;

    localparam int AW_DEF           = 16;   // byte address width
    localparam int DW_DEF           = 16;   // data width
    localparam int STARVE_LIMIT_DEF = 4;    // A grants allowed while B waits
    localparam int CW_DEF           = 4;    // starvation counter width

    // Encoding of a requester's We line
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // Saturating increment for the starvation counter (width fixed by CW_DEF
    // callers pass a value already sized to their counter; this helper works
    // on the widest legal counter and is sliced by the caller).
    function automatic logic [15:0] sat_inc(input logic [15:0] value,
                                            input logic [15:0] max_value);
        sat_inc = (value >= max_value) ? max_value : value + 16'd1;
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// -----------------------------------------------------------------------------
// dm_arbiter_if
// One requester's connection to the arbiter.
//   Req/We/Addr/WData : request, held stable by the requester until Gnt is
//                       sampled high at a rising edge
//   Gnt               : combinational grant for the current cycle
//   RValid/RData      : registered read return, RValid high for one cycle
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface dm_arbiter_if
    import dm_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          Req;
    logic          We;
    logic [AW-1:0] Addr;
    logic [DW-1:0] WData;
    logic          Gnt;
    logic          RValid;
    logic [DW-1:0] RData;

    modport master (
        output Req, We, Addr, WData,
        input  Gnt, RValid, RData
    );

    modport slave (
        input  Req, We, Addr, WData,
        output Gnt, RValid, RData
    );
endinterface

// File: rtl/dm_rdata_reg.sv
// -----------------------------------------------------------------------------
// dm_rdata_reg
// Per-port read-return register. Captures the memory's combinational read data
// on the edge that completes a granted read and flags it valid for exactly the
// following cycle. The data itself holds until the next captured read.
//   Clk, Rst  : clock, synchronous active-high reset
//   cap       : a read for this port is granted this cycle
//   mem_rdata : combinational read data from the memory
//   rvalid    : read data valid (registered)
//   rdata     : read data (registered)
// -----------------------------------------------------------------------------
module dm_rdata_reg
    import dm_arbiter_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          cap,
    input  logic [DW-1:0] mem_rdata,
    output logic          rvalid,
    output logic [DW-1:0] rdata
);

    logic          rvalid_reg;
    logic [DW-1:0] rdata_reg;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            rvalid_reg <= cap;
            if (cap) begin
                rdata_reg <= mem_rdata;
            end
        end
    end

    assign rvalid = rvalid_reg;
    assign rdata  = rdata_reg;

endmodule

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Shares a single-port data memory between port A (CPU load/store, fixed
// priority) and port B (boot loader / debug DMA). One transaction is granted
// per cycle; a starvation counter forces a B grant after STARVE_LIMIT
// consecutive A grants while B waits.
//   Clk, Rst          : clock, synchronous active-high reset
//   a_bus, b_bus      : requester connections (dm_arbiter_if.slave)
//   MemAddr/MemWData  : address / write data to memory (0 when idle)
//   MemRead/MemWrite  : memory strobes for the granted transaction
//   MemRData          : combinational read data from memory
// -----------------------------------------------------------------------------
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int CW           = CW_DEF
) (
    input  logic          Clk,
    input  logic          Rst,
    dm_arbiter_if.slave   a_bus,
    dm_arbiter_if.slave   b_bus,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWData,
    output logic          MemRead,
    output logic          MemWrite,
    input  logic [DW-1:0] MemRData
);

    localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic          force_b;
    logic          a_gnt;
    logic          b_gnt;
    logic [CW-1:0] starve_cnt_reg;
    logic [CW-1:0] starve_cnt_next;

    // ---------------------------------------------------------------- grants
    // Gnt is suppressed during reset so no memory access or capture can be
    // started while the block is being cleared.
    always_comb begin
        force_b = b_bus.Req && (starve_cnt_reg >= LIMIT);
        b_gnt   = !Rst && b_bus.Req && (!a_bus.Req || force_b);
        a_gnt   = !Rst && a_bus.Req && !b_gnt;
    end

    assign a_bus.Gnt = a_gnt;
    assign b_bus.Gnt = b_gnt;

    // ---------------------------------------------------------- memory drive
    always_comb begin
        MemAddr  = '0;
        MemWData = '0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        if (a_gnt) begin
            MemAddr  = a_bus.Addr;
            MemWData = a_bus.WData;
            MemRead  = (a_bus.We == OP_RD);
            MemWrite = (a_bus.We == OP_WR);
        end else if (b_gnt) begin
            MemAddr  = b_bus.Addr;
            MemWData = b_bus.WData;
            MemRead  = (b_bus.We == OP_RD);
            MemWrite = (b_bus.We == OP_WR);
        end
    end

    // ------------------------------------------------------ starvation count
    // Counts A grants taken while B is waiting. Any B grant, or B withdrawing
    // its request, restarts the count.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (b_gnt || !b_bus.Req) begin
            starve_cnt_next = '0;
        end else if (a_gnt) begin
            starve_cnt_next = (starve_cnt_reg == CNT_MAX) ? CNT_MAX
                                                          : starve_cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // -------------------------------------------------- read return per port
    // Index 0 is port A, index 1 is port B.
    logic [1:0]    rd_cap;
    logic [1:0]    rvalid_v;
    logic [DW-1:0] rdata_v [2];

    assign rd_cap[0] = a_gnt && (a_bus.We == OP_RD);
    assign rd_cap[1] = b_gnt && (b_bus.We == OP_RD);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rret
            dm_rdata_reg #(
                .DW (DW)
            ) u_rdata_reg (
                .Clk       (Clk),
                .Rst       (Rst),
                .cap       (rd_cap[gi]),
                .mem_rdata (MemRData),
                .rvalid    (rvalid_v[gi]),
                .rdata     (rdata_v[gi])
            );
        end
    endgenerate

    assign a_bus.RValid = rvalid_v[0];
    assign a_bus.RData  = rdata_v[0];
    assign b_bus.RValid = rvalid_v[1];
    assign b_bus.RData  = rdata_v[1];

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
// Directed bench for dm_arbiter with a small word-addressed memory model.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;
    import dm_arbiter_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          Clk;
    logic          Rst;
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemWData;
    logic          MemRead;
    logic          MemWrite;
    logic [DW-1:0] MemRData;

    dm_arbiter_if #(.AW(AW), .DW(DW)) a_if ();
    dm_arbiter_if #(.AW(AW), .DW(DW)) b_if ();

    dm_arbiter #(
        .AW           (AW),
        .DW           (DW),
        .STARVE_LIMIT (4),
        .CW           (4)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .a_bus    (a_if),
        .b_bus    (b_if),
        .MemAddr  (MemAddr),
        .MemWData (MemWData),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .MemRData (MemRData)
    );

    // Memory model: 256 words, byte address bit 0 ignored, combinational read
    logic [DW-1:0] mem [0:255];
    assign MemRData = mem[MemAddr[8:1]];
    always @(posedge Clk) begin
        if (MemWrite) mem[MemAddr[8:1]] <= MemWData;
    end

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_a(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wd);
        a_if.Req = req; a_if.We = we; a_if.Addr = addr; a_if.WData = wd;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wd);
        b_if.Req = req; b_if.We = we; b_if.Addr = addr; b_if.WData = wd;
    endtask

    logic [9:0] pat_b;

    initial begin
        Rst = 1'b1;
        set_a(1'b0, OP_RD, 16'h0, 16'h0);
        set_b(1'b0, OP_RD, 16'h0, 16'h0);
        tick();
        tick();
        chk("rst_a_rvalid", {31'd0, a_if.RValid}, 32'd0);
        chk("rst_b_rvalid", {31'd0, b_if.RValid}, 32'd0);
        chk("rst_a_rdata", {16'd0, a_if.RData}, 32'd0);
        chk("rst_b_rdata", {16'd0, b_if.RData}, 32'd0);

        // ---- reset mid-read
        Rst = 1'b0;
        set_a(1'b1, OP_RD, 16'h0010, 16'h0);
        #1;
        chk("t1_a_gnt", {31'd0, a_if.Gnt}, 32'd1);
        chk("t1_memread", {31'd0, MemRead}, 32'd1);
        chk("t1_memaddr", {16'd0, MemAddr}, 32'h10);
        tick();
        Rst = 1'b1;
        set_b(1'b1, OP_WR, 16'h0030, 16'hDEAD);
        #1;
        chk("t1_rst_a_gnt", {31'd0, a_if.Gnt}, 32'd0);
        chk("t1_rst_b_gnt", {31'd0, b_if.Gnt}, 32'd0);
        chk("t1_rst_memread", {31'd0, MemRead}, 32'd0);
        chk("t1_rst_memwrite", {31'd0, MemWrite}, 32'd0);
        tick();
        set_a(1'b0, OP_RD, 16'h0, 16'h0);
        #1;
        chk("t1_rst2_b_gnt", {31'd0, b_if.Gnt}, 32'd0);
        chk("t1_rst2_memwrite", {31'd0, MemWrite}, 32'd0);
        chk("t1_after_rst_a_rvalid", {31'd0, a_if.RValid}, 32'd0);
        tick();
        chk("t1_a_rvalid_dropped", {31'd0, a_if.RValid}, 32'd0);
        chk("t1_a_rdata_cleared", {16'd0, a_if.RData}, 32'd0);
        Rst = 1'b0;
        set_b(1'b0, OP_RD, 16'h0, 16'h0);
        tick();

        // ---- A only: write then read
        set_a(1'b1, OP_WR, 16'h0020, 16'h1234);
        #1;
        chk("t2_wr_a_gnt", {31'd0, a_if.Gnt}, 32'd1);
        chk("t2_wr_memwrite", {31'd0, MemWrite}, 32'd1);
        chk("t2_wr_memwdata", {16'd0, MemWData}, 32'h1234);
        chk("t2_wr_b_gnt", {31'd0, b_if.Gnt}, 32'd0);
        tick();
        set_a(1'b1, OP_RD, 16'h0020, 16'h0);
        #1;
        chk("t2_rd_a_gnt", {31'd0, a_if.Gnt}, 32'd1);
        chk("t2_rd_memread", {31'd0, MemRead}, 32'd1);
        chk("t2_rd_memwrite", {31'd0, MemWrite}, 32'd0);
        chk("t2_no_rvalid_after_wr", {31'd0, a_if.RValid}, 32'd0);
        tick();
        set_a(1'b0, OP_RD, 16'h0, 16'h0);
        #1;
        chk("t2_a_rvalid", {31'd0, a_if.RValid}, 32'd1);
        chk("t2_a_rdata", {16'd0, a_if.RData}, 32'h1234);
        chk("t2_idle_memaddr", {16'd0, MemAddr}, 32'd0);
        chk("t2_idle_memread", {31'd0, MemRead}, 32'd0);
        tick();
        chk("t2_a_rvalid_one_cycle", {31'd0, a_if.RValid}, 32'd0);
        chk("t2_a_rdata_hold", {16'd0, a_if.RData}, 32'h1234);

        // ---- B only: preload, then back-to-back reads
        set_b(1'b1, OP_WR, 16'h0002, 16'hAAAA);
        #1;
        chk("t3_wr1_b_gnt", {31'd0, b_if.Gnt}, 32'd1);
        tick();
        set_b(1'b1, OP_WR, 16'h0004, 16'h5555);
        tick();
        set_b(1'b1, OP_RD, 16'h0002, 16'h0);
        #1;
        chk("t3_rd1_b_gnt", {31'd0, b_if.Gnt}, 32'd1);
        chk("t3_rd1_memaddr", {16'd0, MemAddr}, 32'h2);
        tick();
        set_b(1'b1, OP_RD, 16'h0004, 16'h0);
        #1;
        chk("t3_rd2_b_gnt", {31'd0, b_if.Gnt}, 32'd1);
        chk("t3_b_rvalid1", {31'd0, b_if.RValid}, 32'd1);
        chk("t3_b_rdata1", {16'd0, b_if.RData}, 32'hAAAA);
        tick();
        set_b(1'b0, OP_RD, 16'h0, 16'h0);
        #1;
        chk("t3_b_rvalid2", {31'd0, b_if.RValid}, 32'd1);
        chk("t3_b_rdata2", {16'd0, b_if.RData}, 32'h5555);
        chk("t3_a_rvalid_quiet", {31'd0, a_if.RValid}, 32'd0);
        tick();
        chk("t3_b_rvalid_end", {31'd0, b_if.RValid}, 32'd0);

        // ---- contention: A,A,A,A,B repeating (bit i = expected B grant)
        set_a(1'b1, OP_RD, 16'h0020, 16'h0);
        set_b(1'b1, OP_RD, 16'h0002, 16'h0);
        pat_b = 10'b10000_10000;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("t4_cyc%0d_a_gnt", i), {31'd0, a_if.Gnt}, {31'd0, ~pat_b[i]});
            chk($sformatf("t4_cyc%0d_b_gnt", i), {31'd0, b_if.Gnt}, {31'd0, pat_b[i]});
            tick();
        end
        set_a(1'b0, OP_RD, 16'h0, 16'h0);
        set_b(1'b0, OP_RD, 16'h0, 16'h0);
        tick();

        // ---- simultaneous write conflict on 0x0040
        set_a(1'b1, OP_WR, 16'h0040, 16'h1111);
        set_b(1'b1, OP_WR, 16'h0040, 16'h2222);
        #1;
        chk("t5_c1_a_gnt", {31'd0, a_if.Gnt}, 32'd1);
        chk("t5_c1_b_gnt", {31'd0, b_if.Gnt}, 32'd0);
        chk("t5_c1_memwdata", {16'd0, MemWData}, 32'h1111);
        tick();
        set_a(1'b0, OP_RD, 16'h0, 16'h0);
        #1;
        chk("t5_c2_b_gnt", {31'd0, b_if.Gnt}, 32'd1);
        chk("t5_c2_memwdata", {16'd0, MemWData}, 32'h2222);
        chk("t5_c2_memaddr", {16'd0, MemAddr}, 32'h40);
        tick();
        set_b(1'b0, OP_RD, 16'h0, 16'h0);
        #1;
        chk("t5_mem_0040", {16'd0, mem[8'h20]}, 32'h2222);
        set_a(1'b1, OP_RD, 16'h0040, 16'h0);
        tick();
        set_a(1'b0, OP_RD, 16'h0, 16'h0);
        #1;
        chk("t5_readback", {16'd0, a_if.RData}, 32'h2222);
        tick();

        // ---- B withdraws at count 3; a new B request waits 4 more A grants
        set_a(1'b1, OP_RD, 16'h0020, 16'h0);
        set_b(1'b1, OP_RD, 16'h0002, 16'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t6_pre%0d_b_gnt", i), {31'd0, b_if.Gnt}, 32'd0);
            tick();
        end
        set_b(1'b0, OP_RD, 16'h0002, 16'h0);
        #1;
        chk("t6_drop_a_gnt", {31'd0, a_if.Gnt}, 32'd1);
        tick();
        set_b(1'b1, OP_RD, 16'h0002, 16'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t6_wait%0d_b_gnt", i), {31'd0, b_if.Gnt}, 32'd0);
            chk($sformatf("t6_wait%0d_a_gnt", i), {31'd0, a_if.Gnt}, 32'd1);
            tick();
        end
        #1;
        chk("t6_forced_b_gnt", {31'd0, b_if.Gnt}, 32'd1);
        chk("t6_forced_a_gnt", {31'd0, a_if.Gnt}, 32'd0);
        tick();
        set_a(1'b0, OP_RD, 16'h0, 16'h0);
        set_b(1'b0, OP_RD, 16'h0, 16'h0);
        #1;
        chk("t6_forced_b_rdata", {16'd0, b_if.RData}, 32'hAAAA);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
